// File: rtl/jelly_data_gather.sv
`default_nettype none
// ============================================================================
//  jelly_data_gather
//  Merges PORT_NUM valid/ready lanes back into one stream in line order,
//  taking UNIT_SIZE consecutive elements from each port in turn.
//  Optional m_last output: define JELLY_DATA_GATHER_LAST_EN.
//  Revision: 1.0
// ============================================================================
module jelly_data_gather #(
    parameter int PORT_NUM   = 4,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_SIZE  = 640,
    parameter int UNIT_SIZE  = (LINE_SIZE + PORT_NUM - 1) / PORT_NUM
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [PORT_NUM*DATA_WIDTH-1:0] s_data,
    input  logic [PORT_NUM-1:0]            s_valid,
    output logic [PORT_NUM-1:0]            s_ready,
    output logic [DATA_WIDTH-1:0]          m_data,
    output logic                           m_valid,
    input  logic                           m_ready
`ifdef JELLY_DATA_GATHER_LAST_EN
    ,
    output logic                           m_last
`endif
);

    localparam int SEL_W  = (PORT_NUM  > 1) ? $clog2(PORT_NUM)  : 1;
    localparam int UNIT_W = (UNIT_SIZE > 1) ? $clog2(UNIT_SIZE) : 1;
    localparam int LINE_W = (LINE_SIZE > 1) ? $clog2(LINE_SIZE) : 1;

    logic [SEL_W-1:0]      sel_q,        sel_d;
    logic [UNIT_W-1:0]     unit_count_q, unit_count_d;
    logic [LINE_W-1:0]     line_count_q, line_count_d;
    logic                  m_valid_q,    m_valid_d;
    logic [DATA_WIDTH-1:0] m_data_q,     m_data_d;
`ifdef JELLY_DATA_GATHER_LAST_EN
    logic                  m_last_q,     m_last_d;
`endif

    logic                  pready;
    logic                  sel_valid;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  accept;
    logic                  unit_end;
    logic                  line_end;

    // Only the selected lane is ever consulted; others stay stalled upstream.
    always_comb begin
        pready    = !m_valid_q || m_ready;
        sel_valid = 1'b0;
        sel_data  = '0;
        s_ready   = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            if (sel_q == SEL_W'(i)) begin
                sel_valid  = s_valid[i];
                sel_data   = s_data[i*DATA_WIDTH +: DATA_WIDTH];
                s_ready[i] = pready;
            end
        end
        accept   = sel_valid && pready;
        unit_end = (unit_count_q == UNIT_W'(UNIT_SIZE - 1));
        line_end = (line_count_q == LINE_W'(LINE_SIZE - 1));
    end

    always_comb begin
        sel_d        = sel_q;
        unit_count_d = unit_count_q;
        line_count_d = line_count_q;
        m_valid_d    = m_valid_q;
        m_data_d     = m_data_q;
`ifdef JELLY_DATA_GATHER_LAST_EN
        m_last_d     = m_last_q;
`endif
        if (accept) begin
            m_data_d  = sel_data;
            m_valid_d = 1'b1;
`ifdef JELLY_DATA_GATHER_LAST_EN
            m_last_d  = line_end;
`endif
            // Line end wins over unit end so a short last unit returns to port 0.
            if (line_end) begin
                sel_d        = '0;
                unit_count_d = '0;
                line_count_d = '0;
            end else if (unit_end) begin
                sel_d        = (PORT_NUM > 1) ? sel_q + SEL_W'(1) : '0;
                unit_count_d = '0;
                line_count_d = line_count_q + LINE_W'(1);
            end else begin
                unit_count_d = unit_count_q + UNIT_W'(1);
                line_count_d = line_count_q + LINE_W'(1);
            end
        end else if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sel_q        <= '0;
            unit_count_q <= '0;
            line_count_q <= '0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
`ifdef JELLY_DATA_GATHER_LAST_EN
            m_last_q     <= 1'b0;
`endif
        end else begin
            sel_q        <= sel_d;
            unit_count_q <= unit_count_d;
            line_count_q <= line_count_d;
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
`ifdef JELLY_DATA_GATHER_LAST_EN
            m_last_q     <= m_last_d;
`endif
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
`ifdef JELLY_DATA_GATHER_LAST_EN
    assign m_last  = m_last_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_jelly_data_gather.sv
`default_nettype none
// ============================================================================
//  tb_jelly_data_gather
//  Random lane/backpressure/reset stimulus against a line-position model.
//  Revision: 1.0
// ============================================================================
module tb_jelly_data_gather;

    localparam int PORT_NUM   = 4;
    localparam int DATA_WIDTH = 32;
    localparam int LINE_SIZE  = 10;
    localparam int UNIT_SIZE  = 3;
    localparam int DEPTH      = 2048;
    localparam int CYCLES     = 3000;

    logic                           clk = 1'b0;
    logic                           reset;
    logic [PORT_NUM*DATA_WIDTH-1:0] s_data;
    logic [PORT_NUM-1:0]            s_valid;
    logic [PORT_NUM-1:0]            s_ready;
    logic [DATA_WIDTH-1:0]          m_data;
    logic                           m_valid;
    logic                           m_ready;
`ifdef JELLY_DATA_GATHER_LAST_EN
    logic                           m_last;
`endif

    jelly_data_gather #(
        .PORT_NUM   (PORT_NUM),
        .DATA_WIDTH (DATA_WIDTH),
        .LINE_SIZE  (LINE_SIZE),
        .UNIT_SIZE  (UNIT_SIZE)
    ) u_dut (
        .clk     (clk),
        .reset   (reset),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready)
`ifdef JELLY_DATA_GATHER_LAST_EN
        ,
        .m_last  (m_last)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Per-port source streams and consumption counters
    logic [DATA_WIDTH-1:0] gen [PORT_NUM][DEPTH];
    int idx  [PORT_NUM];   // driver position, advanced on DUT handshakes
    int cons [PORT_NUM];   // model position, advanced on model accepts

    // Model state
    int                    e_pos;     // position in the current line
    logic                  mv_exp;
    logic [DATA_WIDTH-1:0] d_exp;
    logic                  l_exp;
    int                    n_out;

    initial begin
        int p_exp;
        logic pready;
        logic acc;
        logic [PORT_NUM-1:0] sr_exp;
        int vprob;
        int rprob;

        for (int p = 0; p < PORT_NUM; p++) begin
            idx[p]  = 0;
            cons[p] = 0;
            for (int n = 0; n < DEPTH; n++) gen[p][n] = $urandom;
        end
        e_pos  = 0;
        mv_exp = 1'b0;
        d_exp  = '0;
        l_exp  = 1'b0;
        n_out  = 0;
        reset   = 1'b0;
        s_valid = '0;
        s_data  = '0;
        m_ready = 1'b0;

        for (int cyc = 0; cyc < CYCLES; cyc++) begin
            @(posedge clk);
            #1;
            // Phases: reset, full-rate streaming, then random valid/ready with rare resets
            if (cyc < 2) begin
                vprob = 0;  rprob = 100; reset = 1'b0;
            end else if (cyc < 400) begin
                vprob = 100; rprob = 100; reset = 1'b1;
            end else if (cyc < 1500) begin
                vprob = 70; rprob = 60;
                reset = ($urandom_range(0, 199) != 0);
            end else begin
                vprob = 40; rprob = 85;
                reset = ($urandom_range(0, 149) != 0);
            end
            m_ready = ($urandom_range(0, 99) < rprob);
            for (int p = 0; p < PORT_NUM; p++) begin
                s_valid[p] = ($urandom_range(0, 99) < vprob);
                s_data[p*DATA_WIDTH +: DATA_WIDTH] =
                    s_valid[p] ? gen[p][idx[p]] : DATA_WIDTH'($urandom);
            end

            @(negedge clk);
            p_exp  = e_pos / UNIT_SIZE;
            pready = !mv_exp || m_ready;
            sr_exp = pready ? PORT_NUM'(1 << p_exp) : '0;

            check("m_valid", 64'(m_valid), 64'(mv_exp));
            check("m_data",  64'(m_data),  64'(d_exp));
            check("s_ready", 64'(s_ready), 64'(sr_exp));
`ifdef JELLY_DATA_GATHER_LAST_EN
            check("m_last",  64'(m_last),  64'(l_exp));
`endif
            if (mv_exp && m_ready) n_out++;

            for (int p = 0; p < PORT_NUM; p++)
                if (reset && s_valid[p] && s_ready[p] && idx[p] < DEPTH - 1) idx[p]++;

            acc = reset && pready && s_valid[p_exp];
            if (!reset) begin
                mv_exp = 1'b0;
                d_exp  = '0;
                l_exp  = 1'b0;
                e_pos  = 0;
            end else if (acc) begin
                d_exp  = gen[p_exp][cons[p_exp]];
                if (cons[p_exp] < DEPTH - 1) cons[p_exp]++;
                l_exp  = (e_pos == LINE_SIZE - 1);
                mv_exp = 1'b1;
                e_pos  = (e_pos == LINE_SIZE - 1) ? 0 : e_pos + 1;
            end else if (mv_exp && m_ready) begin
                mv_exp = 1'b0;
            end
        end

        check("outputs_seen", 64'(n_out > 500), 64'(1));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/jelly_data_gather.md
# jelly_data_gather

Collects PORT_NUM parallel valid/ready streams into one stream, restoring the original line order. Each line of LINE_SIZE elements is rebuilt from consecutive units of UNIT_SIZE elements: the first unit comes from port 0, the next from port 1, and so on. It is the counterpart of the line scatter block and sits after the per-port processing lanes, merging their results back into a single pixel or data stream.

## Interface
- PORT_NUM, 4: number of input ports, ≥1.
- DATA_WIDTH, 32: element width in bits.
- LINE_SIZE, 640: elements per line, ≥1.
- UNIT_SIZE, (LINE_SIZE+PORT_NUM-1)/PORT_NUM: consecutive elements taken from one port, ≥1.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous reset, active-low (0 = reset), sampled on clk.
- s_data  in  PORT_NUM*DATA_WIDTH  port i data at [i*DATA_WIDTH +: DATA_WIDTH].
- s_valid  in  PORT_NUM  per-port valid.
- s_ready  out  PORT_NUM  per-port ready; at most one bit set.
- m_data  out  DATA_WIDTH  merged output data, registered.
- m_valid  out  1  output valid, registered.
- m_ready  in  1  output ready.
- m_last  out  1  last element of line; present only with JELLY_DATA_GATHER_LAST_EN.

## Operation
- Internal state:
  - sel: current port, width clog2(PORT_NUM), minimum 1.
  - unit_count: element count within the current unit, 0..UNIT_SIZE-1.
  - line_count: element count within the current line, 0..LINE_SIZE-1.
- Reset values: sel=0, unit_count=0, line_count=0, m_valid=0, m_data=0, m_last=0.
- Pipeline ready: pready = !m_valid || m_ready.
- s_ready[i] = pready && (sel==i). Non-selected ports always see ready=0. Their data is held upstream, never dropped.
- Accept: s_valid[sel] && s_ready[sel]. On accept:
  - m_data <= s_data[sel];
  - m_valid <= 1;
  - unit_count++ and line_count++.
- End of unit: accept with unit_count==UNIT_SIZE-1 sets unit_count=0 and sel=sel+1.
- End of line: accept with line_count==LINE_SIZE-1 sets sel=0, unit_count=0, line_count=0. End of line has priority over end of unit.
- Short units: if LINE_SIZE is not a multiple of UNIT_SIZE, the last used port supplies only the remaining elements. Ports at or above ceil(LINE_SIZE/UNIT_SIZE) are never selected.
- No accept and m_valid && m_ready: m_valid <= 0.
- Counters are compared, never wrapped by overflow. Widths are clog2 of UNIT_SIZE and LINE_SIZE, minimum 1.
- PORT_NUM==1: sel is constant 0. The block is a one-stage register pipeline with line counting.
- Reset mid-line: the partial line is abandoned, and the next accepted element is element 0 from port 0.

## Timing
- Latency: an element accepted in cycle N appears on m_data/m_valid in cycle N+1.
- Throughput: 1 element/cycle while s_valid[sel]=1 and m_ready=1. Port switches at unit boundaries add no bubble.
- Stall on the selected port: s_valid[sel]=0 inserts a bubble. Other ports are not consulted, even if they are valid.
- m_valid=1 && m_ready=0: m_data, m_valid and m_last hold, and every s_ready bit is 0.
- s_ready has a combinational path from m_ready. There is no s_valid→s_ready path.
- sel, unit_count and line_count change only on accept.

## Configuration
- JELLY_DATA_GATHER_LAST_EN defined:
  - m_last is a port.
  - It registers alongside m_data and is 1 exactly when the emitted element had line_count==LINE_SIZE-1.
- Not defined: the m_last port and its register are absent, and behaviour is otherwise identical.

## Test plan
- Basic order: PORT_NUM=4, LINE_SIZE=8, UNIT_SIZE=2, port i supplies 10*i+k, m_ready=1.
  - m_data must be 0,1,10,11,20,21,30,31, then repeat for the next line.
  - m_valid is continuous after a first-cycle latency of 1.
- Short last unit: LINE_SIZE=10, UNIT_SIZE=3, PORT_NUM=4.
  - Ports supply 3, 3, 3 and 1 elements; port 3 is ready for exactly 1 element per line.
  - The next element after the line comes from port 0.
- Backpressure: m_ready toggles 1,0,0,1 during basic order.
  - While m_ready=0 with m_valid=1: m_data stable and s_ready==0.
  - Output sequence unchanged, no loss or duplication.
- Lane stall: port 1 holds s_valid=0 for 5 cycles after port 0's unit while port 2 is valid.
  - s_ready[2] stays 0 and m_valid drops after draining.
  - Order resumes 10,11,20,... when port 1 becomes valid.
- Reset mid-line: drive reset=0 for 1 cycle after 5 elements of a line.
  - Next cycle: m_valid=0, sel=0.
  - The first output after reset is port 0's element.
- Macro: with JELLY_DATA_GATHER_LAST_EN defined, m_last=1 only on elements 31 (basic) and on the final element of each short-unit line; 0 elsewhere.
